// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the MC-CPU control path.
// These are the opcode values, FSM state codes, ALU/PCSrc/RegOut select codes
// and the instruction classes produced by mc_ctrl_decode.
package mc_cpu_pkg;

  localparam int OPW    = 6;
  localparam int STW    = 3;
  localparam int ALUOPW = 3;

  // Opcodes (IR[31:26])
  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPW-1:0] OP_OR   = 6'b010000;
  localparam logic [OPW-1:0] OP_AND  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPW-1:0] OP_SW   = 6'b110000;
  localparam logic [OPW-1:0] OP_LW   = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPW-1:0] OP_J    = 6'b111000;
  localparam logic [OPW-1:0] OP_JR   = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;

  // FSM states; HALT is a separate flag, not a state
  typedef enum logic [STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  // ALU operation select
  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOPW-1:0] ALU_AND = 3'b100;

  // Next-PC source
  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // Destination register select
  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

  // Instruction classes
  localparam logic [2:0] CL_ALU  = 3'd0;
  localparam logic [2:0] CL_IMM  = 3'd1;
  localparam logic [2:0] CL_LS   = 3'd2;
  localparam logic [2:0] CL_BR   = 3'd3;
  localparam logic [2:0] CL_JMP  = 3'd4;
  localparam logic [2:0] CL_HALT = 3'd5;
  localparam logic [2:0] CL_ILL  = 3'd6;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: maps the opcode to an instruction class plus
// the per-opcode details the FSM needs (ALU op, sign-extend, store, jump source, link).
module mc_ctrl_decode
  import mc_cpu_pkg::*;
(
  input  logic [OPW-1:0]    i_opcode,
  output logic [2:0]        o_cls,
  output logic [ALUOPW-1:0] o_aluop,
  output logic              o_sign_ext,
  output logic              o_store,
  output logic [1:0]        o_jmp_src,
  output logic              o_link
);

  // Opcode lookup; anything not listed decodes as illegal
  always_comb begin
    o_cls      = CL_ILL;
    o_aluop    = ALU_ADD;
    o_sign_ext = 1'b0;
    o_store    = 1'b0;
    o_jmp_src  = PCS_SEQ;
    o_link     = 1'b0;
    case (i_opcode)
      OP_ADD:  o_cls = CL_ALU;
      OP_SUB:  begin o_cls = CL_ALU; o_aluop = ALU_SUB; end
      OP_ADDI: begin o_cls = CL_IMM; o_sign_ext = 1'b1; end
      OP_OR:   begin o_cls = CL_ALU; o_aluop = ALU_OR;  end
      OP_AND:  begin o_cls = CL_ALU; o_aluop = ALU_AND; end
      OP_ORI:  begin o_cls = CL_IMM; o_aluop = ALU_OR;  end
      OP_SW:   begin o_cls = CL_LS;  o_store = 1'b1; end
      OP_LW:   o_cls = CL_LS;
      OP_BEQ:  o_cls = CL_BR;
      OP_J:    begin o_cls = CL_JMP; o_jmp_src = PCS_JMP; end
      OP_JR:   begin o_cls = CL_JMP; o_jmp_src = PCS_RS;  end
      OP_JAL:  begin o_cls = CL_JMP; o_jmp_src = PCS_JMP; o_link = 1'b1; end
      OP_HALT: o_cls = CL_HALT;
      default: o_cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the MC-CPU datapath.
// Optional feature: define MEM_WAIT_EN to add the mem_ready port and stall in MEM
// until the data memory reports completion.
module mc_control_unit
  import mc_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
`ifdef MEM_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic              PCWre,
  output logic              IRWre,
  output logic              RegWre,
  output logic              ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ALUM2Reg,
  output logic [1:0]        RegOut,
  output logic              DataMemRW,
  output logic [1:0]        PCSrc,
  output logic              ExtSel,
  output logic              InsMemRW,
  output logic              WrRegData,
  output logic [STW-1:0]    state,
  output logic [STW-1:0]    next_state,
  output logic              halted
);

  state_t              r_state;
  state_t              w_next;
  logic                r_halted;
  logic                w_halt_go;
  logic                w_mem_done;

  logic [2:0]          w_cls;
  logic [ALUOPW-1:0]   w_dec_aluop;
  logic                w_sign_ext;
  logic                w_store;
  logic [1:0]          w_jmp_src;
  logic                w_link;

  logic                w_pcwre, w_irwre, w_regwre, w_alusrcb, w_alum2reg;
  logic                w_datamemrw, w_extsel, w_wrregdata;
  logic [ALUOPW-1:0]   w_aluop;
  logic [1:0]          w_regout, w_pcsrc;

  mc_ctrl_decode u_decode (
    .i_opcode   (opcode),
    .o_cls      (w_cls),
    .o_aluop    (w_dec_aluop),
    .o_sign_ext (w_sign_ext),
    .o_store    (w_store),
    .o_jmp_src  (w_jmp_src),
    .o_link     (w_link)
  );

`ifdef MEM_WAIT_EN
  assign w_mem_done = mem_ready;
`else
  assign w_mem_done = 1'b1;
`endif

  assign w_halt_go = (r_state == S_ID) && !r_halted && (w_cls == CL_HALT);

  // State and halt-flag registers; halt is sticky until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= r_halted | w_halt_go;
    end
  end

  // Next-state and raw strobe decode from state, opcode class and zero
  always_comb begin
    w_next      = r_state;
    w_pcwre     = 1'b0;
    w_irwre     = 1'b0;
    w_regwre    = 1'b0;
    w_alusrcb   = 1'b0;
    w_aluop     = ALU_ADD;
    w_alum2reg  = 1'b0;
    w_regout    = RO_RA;
    w_datamemrw = 1'b0;
    w_pcsrc     = PCS_SEQ;
    w_extsel    = 1'b0;
    w_wrregdata = 1'b0;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        // While halted the FSM parks in ID with every strobe idle
        if (!r_halted) begin
          case (w_cls)
            CL_JMP: begin
              w_next  = S_IF;
              w_pcwre = 1'b1;
              w_pcsrc = w_jmp_src;
              if (w_link) begin
                w_regwre    = 1'b1;
                w_regout    = RO_RA;
                w_wrregdata = 1'b0;
              end
            end
            CL_ILL: begin
              w_next  = S_IF;
              w_pcwre = 1'b1;
              w_pcsrc = PCS_SEQ;
            end
            CL_HALT: w_next = S_ID;
            CL_BR:   w_next = S_EXE_BR;
            CL_LS:   w_next = S_EXE_LS;
            default: w_next = S_EXE_AL;
          endcase
        end
      end
      S_EXE_AL: begin
        w_next    = S_WB_AL;
        w_aluop   = w_dec_aluop;
        w_alusrcb = (w_cls == CL_IMM);
        w_extsel  = w_sign_ext;
      end
      S_WB_AL: begin
        // ALUOp stays as in EXE so the result being written back is stable
        w_next      = S_IF;
        w_aluop     = w_dec_aluop;
        w_regwre    = 1'b1;
        w_wrregdata = 1'b1;
        w_regout    = (w_cls == CL_ALU) ? RO_RD : RO_RT;
        w_pcwre     = 1'b1;
      end
      S_EXE_BR: begin
        w_next  = S_IF;
        w_aluop = ALU_SUB;
        w_pcwre = 1'b1;
        w_pcsrc = zero ? PCS_BR : PCS_SEQ;
      end
      S_EXE_LS: begin
        w_next    = S_MEM;
        w_aluop   = ALU_ADD;
        w_alusrcb = 1'b1;
        w_extsel  = 1'b1;
      end
      S_MEM: begin
        // The memory strobe is held across a stall, but the PC only
        // advances on the cycle the access completes
        w_aluop     = ALU_ADD;
        w_datamemrw = w_store;
        w_pcwre     = w_store & w_mem_done;
        if (w_mem_done) w_next = w_store ? S_IF : S_WB_LD;
      end
      S_WB_LD: begin
        w_next      = S_IF;
        w_aluop     = ALU_ADD;
        w_regwre    = 1'b1;
        w_wrregdata = 1'b1;
        w_alum2reg  = 1'b1;
        w_regout    = RO_RT;
        w_pcwre     = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // Reset forces every output low so no partial writeback can escape
  assign PCWre      = reset & w_pcwre;
  assign IRWre      = reset & w_irwre;
  assign RegWre     = reset & w_regwre;
  assign DataMemRW  = reset & w_datamemrw;
  assign ALUSrcB    = reset & w_alusrcb;
  assign ALUM2Reg   = reset & w_alum2reg;
  assign ExtSel     = reset & w_extsel;
  assign WrRegData  = reset & w_wrregdata;
  assign InsMemRW   = reset;
  assign ALUOp      = reset ? w_aluop  : '0;
  assign RegOut     = reset ? w_regout : '0;
  assign PCSrc      = reset ? w_pcsrc  : '0;
  assign state      = reset ? r_state  : '0;
  assign next_state = reset ? w_next   : '0;
  assign halted     = reset & r_halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit (default build and MEM_WAIT_EN build).
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, DataMemRW;
  logic       ExtSel, InsMemRW, WrRegData, halted;
  logic [2:0] ALUOp, state, next_state;
  logic [1:0] RegOut, PCSrc;

  int checks = 0;
  int errors = 0;

  mc_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .RegWre     (RegWre),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ALUM2Reg   (ALUM2Reg),
    .RegOut     (RegOut),
    .DataMemRW  (DataMemRW),
    .PCSrc      (PCSrc),
    .ExtSel     (ExtSel),
    .InsMemRW   (InsMemRW),
    .WrRegData  (WrRegData),
    .state      (state),
    .next_state (next_state),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    tick; tick;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if ({PCWre, IRWre, RegWre, DataMemRW} !== 4'b0000) begin errors++; $display("FAIL rst_wen: got %b expected 0000", {PCWre, IRWre, RegWre, DataMemRW}); end
    checks++; if (InsMemRW !== 1'b0) begin errors++; $display("FAIL rst_insmem: got %b expected 0", InsMemRW); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
    reset = 1'b1;
    #1;
    checks++; if (InsMemRW !== 1'b1) begin errors++; $display("FAIL rel_insmem: got %b expected 1", InsMemRW); end
    checks++; if (IRWre !== 1'b1) begin errors++; $display("FAIL rel_irwre: got %b expected 1", IRWre); end
    $display("reset: released in IF");
  endtask

  task automatic test_alu_add;
    logic [2:0] st  [5] = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd0};
    logic       pcw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== st[i]) begin errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      checks++; if (PCWre !== pcw[i]) begin errors++; $display("FAIL add_pcwre[%0d]: got %b expected %b", i, PCWre, pcw[i]); end
      checks++; if (RegWre !== pcw[i]) begin errors++; $display("FAIL add_regwre[%0d]: got %b expected %b", i, RegWre, pcw[i]); end
      if (i == 3) begin
        checks++; if (RegOut !== 2'b10) begin errors++; $display("FAIL add_regout: got %b expected 10", RegOut); end
        checks++; if (WrRegData !== 1'b1) begin errors++; $display("FAIL add_wrregdata: got %b expected 1", WrRegData); end
      end
      if (i < 4) tick;
    end
    $display("ADD: 4 cycles");
  endtask

  task automatic test_alu_ops;
    logic [5:0] ops [4] = '{6'b000001, 6'b010010, 6'b000010, 6'b010001};
    logic [2:0] aop [4] = '{3'b001,    3'b011,    3'b000,    3'b100};
    logic [1:0] ro  [4] = '{2'b10,     2'b01,     2'b01,     2'b10};
    logic       src [4] = '{1'b0,      1'b1,      1'b1,      1'b0};
    logic       ext [4] = '{1'b0,      1'b0,      1'b1,      1'b0};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      tick;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL op%0d_id: got %0d expected 1", k, state); end
      tick;
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL op%0d_exe: got %0d expected 6", k, state); end
      checks++; if (ALUOp !== aop[k]) begin errors++; $display("FAIL op%0d_aluop_exe: got %b expected %b", k, ALUOp, aop[k]); end
      checks++; if (ALUSrcB !== src[k]) begin errors++; $display("FAIL op%0d_alusrcb: got %b expected %b", k, ALUSrcB, src[k]); end
      checks++; if (ExtSel !== ext[k]) begin errors++; $display("FAIL op%0d_extsel: got %b expected %b", k, ExtSel, ext[k]); end
      tick;
      checks++; if (state !== 3'd7) begin errors++; $display("FAIL op%0d_wb: got %0d expected 7", k, state); end
      checks++; if (ALUOp !== aop[k]) begin errors++; $display("FAIL op%0d_aluop_wb: got %b expected %b", k, ALUOp, aop[k]); end
      checks++; if (RegOut !== ro[k]) begin errors++; $display("FAIL op%0d_regout: got %b expected %b", k, RegOut, ro[k]); end
      checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL op%0d_regwre: got %b expected 1", k, RegWre); end
      tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL op%0d_ret: got %0d expected 0", k, state); end
      $display("ALU op %b: 4 cycles", ops[k]);
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b110100; zero = z[0];
      tick;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL beq%0d_id: got %0d expected 1", z, state); end
      checks++; if (PCWre !== 1'b0) begin errors++; $display("FAIL beq%0d_id_pcwre: got %b expected 0", z, PCWre); end
      tick;
      checks++; if (state !== 3'd5) begin errors++; $display("FAIL beq%0d_exe: got %0d expected 5", z, state); end
      checks++; if (PCWre !== 1'b1) begin errors++; $display("FAIL beq%0d_pcwre: got %b expected 1", z, PCWre); end
      checks++; if (PCSrc !== {1'b0, z[0]}) begin errors++; $display("FAIL beq%0d_pcsrc: got %b expected %b", z, PCSrc, {1'b0, z[0]}); end
      checks++; if (ALUOp !== 3'b001) begin errors++; $display("FAIL beq%0d_aluop: got %b expected 001", z, ALUOp); end
      tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq%0d_ret: got %0d expected 0", z, state); end
      $display("BEQ zero=%0d: 3 cycles", z);
    end
    zero = 1'b0;
  endtask

  task automatic test_load_store;
    logic [2:0] lst [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic       lwb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] sst [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       smm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b110001;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== lst[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, lst[i]); end
      checks++; if (RegWre !== lwb[i]) begin errors++; $display("FAIL lw_regwre[%0d]: got %b expected %b", i, RegWre, lwb[i]); end
      checks++; if (ALUM2Reg !== lwb[i]) begin errors++; $display("FAIL lw_alum2reg[%0d]: got %b expected %b", i, ALUM2Reg, lwb[i]); end
      if (i == 2) begin
        checks++; if ({ALUSrcB, ExtSel} !== 2'b11) begin errors++; $display("FAIL lw_exe_src_ext: got %b expected 11", {ALUSrcB, ExtSel}); end
      end
      if (i < 5) tick;
    end
    $display("LW: 5 cycles");
    opcode = 6'b110000;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== sst[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, sst[i]); end
      checks++; if (DataMemRW !== smm[i]) begin errors++; $display("FAIL sw_memrw[%0d]: got %b expected %b", i, DataMemRW, smm[i]); end
      checks++; if (PCWre !== smm[i]) begin errors++; $display("FAIL sw_pcwre[%0d]: got %b expected %b", i, PCWre, smm[i]); end
      if (i < 4) tick;
    end
    $display("SW: 4 cycles");
  endtask

  task automatic test_jump;
    logic [5:0] ops [4] = '{6'b111010, 6'b111001, 6'b111000, 6'b101010};
    logic [1:0] pcs [4] = '{2'b11,     2'b10,     2'b11,     2'b00};
    logic       lnk [4] = '{1'b1,      1'b0,      1'b0,      1'b0};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      tick;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL jmp%0d_id: got %0d expected 1", k, state); end
      checks++; if (PCWre !== 1'b1) begin errors++; $display("FAIL jmp%0d_pcwre: got %b expected 1", k, PCWre); end
      checks++; if (PCSrc !== pcs[k]) begin errors++; $display("FAIL jmp%0d_pcsrc: got %b expected %b", k, PCSrc, pcs[k]); end
      checks++; if (RegWre !== lnk[k]) begin errors++; $display("FAIL jmp%0d_regwre: got %b expected %b", k, RegWre, lnk[k]); end
      checks++; if ({RegOut, WrRegData} !== 3'b000) begin errors++; $display("FAIL jmp%0d_regout_wrd: got %b expected 000", k, {RegOut, WrRegData}); end
      checks++; if (next_state !== 3'd0) begin errors++; $display("FAIL jmp%0d_next: got %0d expected 0", k, next_state); end
      tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL jmp%0d_ret: got %0d expected 0", k, state); end
      $display("jump-class op %b: 2 cycles", ops[k]);
    end
  endtask

  task automatic test_halt;
    opcode = 6'b111111;
    tick;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL halt_id: got %0d expected 1", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag[%0d]: got %b expected 1", i, halted); end
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL halt_state[%0d]: got %0d expected 1", i, state); end
      checks++; if ({PCWre, RegWre} !== 2'b00) begin errors++; $display("FAIL halt_wen[%0d]: got %b expected 00", i, {PCWre, RegWre}); end
    end
    reset = 1'b0; opcode = 6'b000000;
    #1;
    checks++; if ({halted, PCWre} !== 2'b00) begin errors++; $display("FAIL halt_rst_out: got %b expected 00", {halted, PCWre}); end
    tick;
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL halt_rel_state: got %0d expected 0", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rel_flag: got %b expected 0", halted); end
    tick;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL halt_resume: got %0d expected 1", state); end
    tick; tick; tick;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL halt_resume_ret: got %0d expected 0", state); end
    $display("HALT: held 20 cycles, cleared by reset");
  endtask

  task automatic test_reset_mid;
    opcode = 6'b000000;
    tick; tick; tick;
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL mid_wb: got %0d expected 7", state); end
    checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL mid_wb_regwre: got %b expected 1", RegWre); end
    reset = 1'b0;
    #1;
    checks++; if ({RegWre, PCWre} !== 2'b00) begin errors++; $display("FAIL mid_rst_wen: got %b expected 00", {RegWre, PCWre}); end
    tick;
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_rel_state: got %0d expected 0", state); end
    checks++; if ({IRWre, RegWre} !== 2'b10) begin errors++; $display("FAIL mid_rel_strobes: got %b expected 10", {IRWre, RegWre}); end
    tick;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL mid_resume: got %0d expected 1", state); end
    tick; tick; tick;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_resume_ret: got %0d expected 0", state); end
    $display("reset in WB_AL: no writeback, restart in IF");
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait;
    opcode = 6'b110000; mem_ready = 1'b0;
    tick; tick; tick;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      #1;
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL wait_state[%0d]: got %0d expected 3", c, state); end
      checks++; if (DataMemRW !== 1'b1) begin errors++; $display("FAIL wait_memrw[%0d]: got %b expected 1", c, DataMemRW); end
      checks++; if (PCWre !== (c == 3)) begin errors++; $display("FAIL wait_pcwre[%0d]: got %b expected %b", c, PCWre, (c == 3)); end
      if (c < 3) tick;
    end
    tick;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL wait_ret: got %0d expected 0", state); end
    $display("SW with 3 wait cycles: MEM held 4 cycles");
  endtask
`endif

  initial begin
    test_reset;
    test_alu_add;
    test_alu_ops;
    test_beq;
    test_load_store;
    test_jump;
    test_halt;
    test_reset_mid;
`ifdef MEM_WAIT_EN
    test_mem_wait;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
